// File: rtl/reset_sequencer.sv
// Sequenced release of a bank of subsystem resets after the startup reset request falls.
// Stages leave reset in ascending order, STAGE_DELAY cycles apart; any new request re-asserts all.
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_DELAY   = 8,
    parameter int COUNTER_WIDTH = 4,
    parameter int INDEX_WIDTH   = 2
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   trigger_in,
    output logic [NUM_STAGES-1:0]  stage_reset,
    output logic [INDEX_WIDTH-1:0] released_count,
    output logic                   done
);

    typedef enum logic [1:0] {
        ARM,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_TICK  = COUNTER_WIDTH'(STAGE_DELAY - 1);
    localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX = INDEX_WIDTH'(NUM_STAGES - 1);

    state_t                   state;
    state_t                   state_next;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [COUNTER_WIDTH-1:0] counter_next;
    logic [NUM_STAGES-1:0]    stage_next;
    logic [INDEX_WIDTH-1:0]   count_next;
    logic                     done_next;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state          <= ARM;
            stage_reset    <= '1;
            released_count <= '0;
            done           <= 1'b0;
            counter        <= '0;
        end else begin
            state          <= state_next;
            stage_reset    <= stage_next;
            released_count <= count_next;
            done           <= done_next;
            counter        <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        stage_next   = stage_reset;
        count_next   = released_count;
        done_next    = done;
        counter_next = counter;

        case (state)
            ARM: begin
                stage_next   = '1;
                count_next   = '0;
                done_next    = 1'b0;
                counter_next = '0;
                if (trigger_in) begin
                    state_next = HOLD;
                end
            end

            HOLD: begin
                stage_next   = '1;
                count_next   = '0;
                done_next    = 1'b0;
                counter_next = '0;
                if (!trigger_in) begin
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                // A request on the same edge as a due release wins; nothing deasserts.
                if (trigger_in) begin
                    state_next   = HOLD;
                    stage_next   = '1;
                    count_next   = '0;
                    done_next    = 1'b0;
                    counter_next = '0;
                end else if (counter == LAST_TICK) begin
                    stage_next   = stage_reset << 1;
                    count_next   = released_count + INDEX_WIDTH'(1);
                    counter_next = '0;
                    if (released_count == LAST_INDEX) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    counter_next = counter + COUNTER_WIDTH'(1);
                end
            end

            DONE: begin
                if (trigger_in) begin
                    state_next   = HOLD;
                    stage_next   = '1;
                    count_next   = '0;
                    done_next    = 1'b0;
                    counter_next = '0;
                end
            end

            default: begin
                state_next = ARM;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two instances (STAGE_DELAY 8 and 1) share stimulus;
// expected outputs come from a time-since-request-fell model and are checked every cycle.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       trig;
    logic [2:0] stage_a;
    logic [1:0] count_a;
    logic       done_a;
    logic [2:0] stage_b;
    logic [1:0] count_b;
    logic       done_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int mode;   // 0 idle/armed, 1 request held, 2 counting since request fell
        int t;      // edges since the request fell
    } mdl_t;

    typedef struct {
        logic [7:0] stage;
        int         count;
        logic       done;
    } exp_t;

    mdl_t ma;
    mdl_t mb;
    exp_t qa[$];
    exp_t qb[$];

    reset_sequencer #(
        .NUM_STAGES   (3),
        .STAGE_DELAY  (8),
        .COUNTER_WIDTH(4),
        .INDEX_WIDTH  (2)
    ) dut_a (
        .clk_in        (clk),
        .reset         (reset),
        .trigger_in    (trig),
        .stage_reset   (stage_a),
        .released_count(count_a),
        .done          (done_a)
    );

    reset_sequencer #(
        .NUM_STAGES   (3),
        .STAGE_DELAY  (1),
        .COUNTER_WIDTH(1),
        .INDEX_WIDTH  (2)
    ) dut_b (
        .clk_in        (clk),
        .reset         (reset),
        .trigger_in    (trig),
        .stage_reset   (stage_b),
        .released_count(count_b),
        .done          (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model_step(inout mdl_t m, input logic r, input logic tr,
                                        input int n, input int d);
        exp_t e;
        int   rel;
        rel = 0;
        if (!r) begin
            m.mode = 0;
            m.t    = 0;
        end else if (m.mode == 0) begin
            if (tr) m.mode = 1;
        end else if (m.mode == 1) begin
            if (!tr) begin
                m.mode = 2;
                m.t    = 0;
            end
        end else begin
            if (tr) begin
                m.mode = 1;
                m.t    = 0;
            end else begin
                m.t = m.t + 1;
            end
        end
        if (m.mode == 2) begin
            rel = m.t / d;
            if (rel > n) rel = n;
        end
        e.stage = (8'hFF << rel) & 8'((1 << n) - 1);
        e.count = rel;
        e.done  = (rel == n);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic t);
        reset = r;
        trig  = t;
        qa.push_back(model_step(ma, r, t, 3, 8));
        qb.push_back(model_step(mb, r, t, 3, 1));
        @(negedge clk);
    endtask

    task automatic run(input logic r, input logic t, input int n);
        for (int i = 0; i < n; i++) drive(r, t);
    endtask

    // Monitor: one popped expectation per instance per clock edge.
    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_stage_reset", int'(stage_a), int'(ea.stage[2:0]));
                check("a_released_count", int'(count_a), ea.count);
                check("a_done", int'(done_a), int'(ea.done));
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("b_stage_reset", int'(stage_b), int'(eb.stage[2:0]));
                check("b_released_count", int'(count_b), eb.count);
                check("b_done", int'(done_b), int'(eb.done));
            end
        end
    end

    initial begin
        ma = '{mode: 0, t: 0};
        mb = '{mode: 0, t: 0};
        reset = 1'b0;
        trig  = 1'b0;

        // Power-up sequence
        run(0, 0, 2);
        run(1, 1, 16);
        run(1, 0, 30);
        // Retrigger mid-release, then full release
        run(1, 1, 3);
        run(1, 0, 10);
        run(1, 1, 2);
        run(1, 0, 30);
        // Request collides with the second release
        run(1, 1, 2);
        run(1, 0, 16);
        run(1, 1, 1);
        run(1, 0, 40);
        // Reset mid-operation with the request already high
        run(1, 1, 2);
        run(1, 0, 12);
        run(0, 1, 1);
        run(1, 1, 2);
        run(1, 0, 30);
        // No request after reset
        run(0, 0, 2);
        run(1, 0, 100);

        // Randomized segments
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                run(0, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
            end
            run(1, 1, $urandom_range(1, 4));
            run(1, 0, $urandom_range(1, 35));
        end

        for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        check("scoreboard_drain", qa.size() + qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
